// File: rtl/op_aut_mc.sv
// op_aut_mc: multi-cycle MIPS-subset operational automaton.
// The internal FSM steps IDLE -> FETCH -> DECODE -> EXEC -> WB. Instruction
// fetch uses a req/ack handshake, so slow instruction memories just stretch
// FETCH.
// Ports:
//   clock, reset (async active-low), run (start/continue)
//   imem_req/imem_addr/imem_ack/imem_data : instruction fetch handshake
//   dbg_addr/dbg_data : combinational register-file debug read
//   pc, state : architectural PC and FSM state (IDLE=0..WB=4)
//   retired/illegal : one-cycle pulses in WB; zero : ALU==0 from last EXEC
module op_aut_mc #(
  parameter int               WIDTH    = 32,
  parameter int               REGS     = 32,
  parameter logic [WIDTH-1:0] PC_RESET = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] pc,
  output logic [2:0]       state,
  output logic             retired,
  output logic             illegal,
  output logic             zero
);

  localparam int         AW     = (REGS > 1) ? $clog2(REGS) : 1;
  localparam logic [5:0] REGS_L = 6'(REGS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_pc;
  logic [31:0]      r_ir;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_alu;
  logic             r_zero;
  logic [WIDTH-1:0] r_rf [REGS];

  // A register index is backed by storage only when nonzero and below REGS;
  // everything else reads as zero and swallows writes.
  function automatic logic idx_ok(input logic [4:0] idx);
    return (idx != 5'd0) && ({1'b0, idx} < REGS_L);
  endfunction

  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic             w_is_r;
  logic             w_r_legal;
  logic             w_is_addi;
  logic             w_is_beq;
  logic             w_is_bne;
  logic             w_is_j;
  logic             w_legal;
  logic [WIDTH-1:0] w_imm_sext;
  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_j_tgt;
  logic [WIDTH-1:0] w_pc_nx;
  logic [WIDTH-1:0] w_rs_val;
  logic [WIDTH-1:0] w_rt_val;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_vld;
  logic             w_wr_en;
  logic [4:0]       w_wr_idx;
  logic             w_unused_shamt;

  assign w_op       = r_ir[31:26];
  assign w_funct    = r_ir[5:0];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_is_r     = (w_op == 6'b000000);
  assign w_r_legal  = (w_funct == 6'b100000) || (w_funct == 6'b100010) ||
                      (w_funct == 6'b100100) || (w_funct == 6'b100101) ||
                      (w_funct == 6'b101010);
  assign w_is_addi  = (w_op == 6'b001000);
  assign w_is_beq   = (w_op == 6'b000100);
  assign w_is_bne   = (w_op == 6'b000101);
  assign w_is_j     = (w_op == 6'b000010);
  assign w_legal    = (w_is_r && w_r_legal) || w_is_addi || w_is_beq ||
                      w_is_bne || w_is_j;
  assign w_unused_shamt = ^r_ir[10:6];

  assign w_imm_sext = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};
  assign w_pc4      = r_pc + WIDTH'(4);
  assign w_br_tgt   = w_pc4 + {w_imm_sext[WIDTH-3:0], 2'b00};
  assign w_j_tgt    = {w_pc4[WIDTH-1:28], r_ir[25:0], 2'b00};

  assign w_rs_val = idx_ok(w_rs)     ? r_rf[w_rs[AW-1:0]]     : {WIDTH{1'b0}};
  assign w_rt_val = idx_ok(w_rt)     ? r_rf[w_rt[AW-1:0]]     : {WIDTH{1'b0}};
  assign dbg_data = idx_ok(dbg_addr) ? r_rf[dbg_addr[AW-1:0]] : {WIDTH{1'b0}};

  assign w_wr_idx = w_is_r ? w_rd : w_rt;
  assign w_wr_en  = (r_state == S_WB) && ((w_is_r && w_r_legal) || w_is_addi) &&
                    idx_ok(w_wr_idx);

  assign state     = r_state;
  assign pc        = r_pc;
  assign imem_addr = r_pc;
  assign imem_req  = (r_state == S_FETCH);
  assign retired   = (r_state == S_WB);
  assign illegal   = (r_state == S_WB) && !w_legal;
  assign zero      = r_zero;

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; run is only looked at in IDLE and WB.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   w_state_nx = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_state_nx = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: w_state_nx = S_EXEC;
      S_EXEC:   w_state_nx = S_WB;
      S_WB:     w_state_nx = run ? S_FETCH : S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // ALU; j and illegal encodings perform no operation and leave zero alone.
  always_comb begin
    w_alu_res = {WIDTH{1'b0}};
    w_alu_vld = 1'b0;
    if (w_is_r) begin
      w_alu_vld = w_r_legal;
      case (w_funct)
        6'b100000: w_alu_res = r_a + r_b;
        6'b100010: w_alu_res = r_a - r_b;
        6'b100100: w_alu_res = r_a & r_b;
        6'b100101: w_alu_res = r_a | r_b;
        6'b101010: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
        default:   w_alu_res = {WIDTH{1'b0}};
      endcase
    end else if (w_is_addi) begin
      w_alu_vld = 1'b1;
      w_alu_res = r_a + w_imm_sext;
    end else if (w_is_beq || w_is_bne) begin
      w_alu_vld = 1'b1;
      w_alu_res = r_a - r_b;
    end else begin
      w_alu_vld = 1'b0;
      w_alu_res = {WIDTH{1'b0}};
    end
  end

  // PC selection for WB: taken branch, jump, or sequential.
  always_comb begin
    w_pc_nx = w_pc4;
    if (w_is_beq && r_zero) begin
      w_pc_nx = w_br_tgt;
    end else if (w_is_bne && !r_zero) begin
      w_pc_nx = w_br_tgt;
    end else if (w_is_j) begin
      w_pc_nx = w_j_tgt;
    end else begin
      w_pc_nx = w_pc4;
    end
  end

  // Datapath registers: IR, operands, ALU result, zero flag and PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc   <= PC_RESET;
      r_ir   <= 32'd0;
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_alu  <= {WIDTH{1'b0}};
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) r_ir <= imem_data;
        end
        S_DECODE: begin
          r_a <= w_rs_val;
          r_b <= w_rt_val;
        end
        S_EXEC: begin
          if (w_alu_vld) begin
            r_alu  <= w_alu_res;
            r_zero <= (w_alu_res == {WIDTH{1'b0}});
          end
        end
        S_WB: begin
          r_pc <= w_pc_nx;
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  // Register file; cleared by reset, written only in WB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) r_rf[i] <= {WIDTH{1'b0}};
    end else if (w_wr_en) begin
      r_rf[w_wr_idx[AW-1:0]] <= r_alu;
    end
  end

endmodule

// File: tb/tb_op_aut_mc.sv
`timescale 1ns/1ps
module tb_op_aut_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic [4:0]  dbg_addr = 5'd0;

  logic        imem_req, retired, illegal, zero;
  logic [31:0] imem_addr, dbg_data, pc;
  logic [2:0]  state;
  logic        imem_req8, retired8, illegal8, zero8;
  logic [31:0] imem_addr8, dbg_data8, pc8;
  logic [2:0]  state8;

  op_aut_mc #(.WIDTH(32), .REGS(32), .PC_RESET(32'd0)) dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc), .state(state),
    .retired(retired), .illegal(illegal), .zero(zero));

  op_aut_mc #(.WIDTH(32), .REGS(8), .PC_RESET(32'd0)) dut8 (
    .clock(clock), .reset(reset), .run(run),
    .imem_req(imem_req8), .imem_addr(imem_addr8), .imem_ack(imem_ack), .imem_data(imem_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data8), .pc(pc8), .state(state8),
    .retired(retired8), .illegal(illegal8), .zero(zero8));

  always #50 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_rf [32];
  logic        m_zero;
  logic        m_zero_vld;
  logic        m_illegal;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    m_zero = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  // Architectural effect of one instruction, computed from the ISA rules.
  task automatic model_exec(input logic [31:0] ins);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b, imm, res, pc4, npc;
    int dst;
    op = ins[31:26];
    fn = ins[5:0];
    a = m_rf[ins[25:21]];
    b = m_rf[ins[20:16]];
    imm = {{16{ins[15]}}, ins[15:0]};
    pc4 = m_pc + 32'd4;
    npc = pc4;
    res = 32'd0;
    dst = 0;
    m_zero_vld = 1'b0;
    m_illegal = 1'b0;
    case (op)
      6'h00: begin
        m_zero_vld = 1'b1;
        dst = int'(ins[15:11]);
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin m_illegal = 1'b1; m_zero_vld = 1'b0; dst = 0; end
        endcase
      end
      6'h08: begin res = a + imm; m_zero_vld = 1'b1; dst = int'(ins[20:16]); end
      6'h04: begin res = a - b; m_zero_vld = 1'b1; if (a == b) npc = pc4 + imm * 32'd4; end
      6'h05: begin res = a - b; m_zero_vld = 1'b1; if (a != b) npc = pc4 + imm * 32'd4; end
      6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
      default: m_illegal = 1'b1;
    endcase
    if (m_zero_vld) m_zero = (res == 32'd0);
    if (dst != 0) m_rf[dst] = res;
    m_pc = npc;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      checks++;
      if (dbg_data !== m_rf[i]) begin
        errors++;
        $display("FAIL %s_reg r%0d got=%h want=%h", tag, i, dbg_data, m_rf[i]);
      end
    end
  endtask

  // Runs one instruction with `delay` cycles of ack wait, checking handshake,
  // latency, pulses, zero, pc and the whole register file.
  task automatic exec_instr(input logic [31:0] ins, input int delay, input logic run_after);
    int n;
    run = 1'b1;
    n = 0;
    while (state !== 3'd1 && n < 20) begin tick(); n++; end
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL fetch_timeout state=%0d want=1", state);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      imem_data = $urandom;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || state !== 3'd1) begin
        errors++;
        $display("FAIL fetch_hold req=%b addr=%h state=%0d want req=1 addr=%h state=1",
                 imem_req, imem_addr, state, m_pc);
      end
      tick();
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_addr req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, m_pc);
    end
    imem_ack = 1'b1;
    imem_data = ins;
    tick();
    // stray acks with junk data outside FETCH must be ignored
    imem_ack = 1'($urandom_range(0, 1));
    imem_data = $urandom;
    tick();
    tick();
    imem_ack = 1'b0;
    run = run_after;
    model_exec(ins);
    checks++;
    if (state !== 3'd4 || retired !== 1'b1 || illegal !== m_illegal || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL wb_pulse ins=%h state=%0d ret=%b ill=%b req=%b want state=4 ret=1 ill=%b req=0",
               ins, state, retired, illegal, imem_req, m_illegal);
    end
    if (m_zero_vld) begin
      checks++;
      if (zero !== m_zero) begin
        errors++;
        $display("FAIL zero ins=%h got=%b want=%b", ins, zero, m_zero);
      end
    end
    tick();
    checks++;
    if (pc !== m_pc || retired !== 1'b0 || illegal !== 1'b0 || state !== (run_after ? 3'd1 : 3'd0)) begin
      errors++;
      $display("FAIL after_wb ins=%h pc=%h ret=%b ill=%b state=%0d want pc=%h ret=0 ill=0 state=%0d",
               ins, pc, retired, illegal, state, m_pc, run_after ? 1 : 0);
    end
    check_regs("exec");
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run = 1'b0;
    tick();
    tick();
    model_reset();
    checks++;
    if (state !== 3'd0 || pc !== 32'd0 || imem_req !== 1'b0 || retired !== 1'b0 ||
        illegal !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state state=%0d pc=%h req=%b ret=%b ill=%b zero=%b want all 0",
               state, pc, imem_req, retired, illegal, zero);
    end
    check_regs("reset");
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold state=%0d want=0", state);
    end
  endtask

  task automatic test_program();
    exec_instr(32'h20010005, 0, 1'b1);           // addi r1,r0,5
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (dbg_data !== 32'd5 || pc !== 32'd4) begin
      errors++;
      $display("FAIL first_addi r1=%h pc=%h want r1=5 pc=4", dbg_data, pc);
    end
    exec_instr(32'h20020007, 0, 1'b1);           // addi r2,r0,7
    exec_instr(32'h00221820, 0, 1'b1);           // add r3,r1,r2
    dbg_addr = 5'd3;
    #1;
    checks++;
    if (dbg_data !== 32'd12) begin
      errors++;
      $display("FAIL add r3=%h want=%h", dbg_data, 32'd12);
    end
    exec_instr(32'h00222022, 0, 1'b1);           // sub r4,r1,r2
    dbg_addr = 5'd4;
    #1;
    checks++;
    if (dbg_data !== 32'hFFFF_FFFE || zero !== 1'b0 || pc !== 32'h10) begin
      errors++;
      $display("FAIL sub r4=%h zero=%b pc=%h want r4=fffffffe zero=0 pc=10", dbg_data, zero, pc);
    end
  endtask

  task automatic test_branch();
    exec_instr(32'h10210002, 0, 1'b1);           // beq r1,r1,+2 at 0x10
    checks++;
    if (pc !== 32'h1C) begin
      errors++;
      $display("FAIL beq pc=%h want=1c", pc);
    end
    exec_instr(32'h14210002, 0, 1'b1);           // bne r1,r1,+2 (not taken)
    checks++;
    if (pc !== 32'h20) begin
      errors++;
      $display("FAIL bne pc=%h want=20", pc);
    end
    exec_instr(32'h08000040, 1, 1'b1);           // j 0x100
    exec_instr(32'h1422FFFC, 0, 1'b1);           // bne r1,r2,-4 (taken backwards)
  endtask

  task automatic test_ack_delay();
    exec_instr(32'h20050063, 3, 1'b1);           // addi r5,r0,99 with 3 wait cycles
    checks++;
    if (imem_addr !== m_pc || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL next_fetch addr=%h req=%b want addr=%h req=1", imem_addr, imem_req, m_pc);
    end
  endtask

  task automatic test_r0_illegal_regs();
    exec_instr(32'h20000009, 0, 1'b1);           // addi r0,r0,9
    exec_instr(32'hFC000000, 0, 1'b1);           // opcode 0x3F
    exec_instr(32'h0022183F, 2, 1'b1);           // R-type with unknown funct
    exec_instr(32'h20090001, 0, 1'b0);           // addi r9,r0,1
    dbg_addr = 5'd9;
    #1;
    checks++;
    if (dbg_data8 !== 32'd0 || pc8 !== m_pc) begin
      errors++;
      $display("FAIL small_regs r9=%h pc=%h want r9=0 pc=%h", dbg_data8, pc8, m_pc);
    end
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (dbg_data8 !== m_rf[1]) begin
      errors++;
      $display("FAIL small_regs_r1 got=%h want=%h", dbg_data8, m_rf[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [5:0]  fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    for (int k = 0; k < 150; k++) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0, 1: begin ins[31:26] = 6'h00; ins[5:0] = fns[$urandom_range(0, 4)]; end
        2:    ins[31:26] = 6'h08;
        3:    ins[31:26] = 6'h04;
        4:    ins[31:26] = 6'h05;
        5:    ins[31:26] = 6'h02;
        6:    ins[31:26] = 6'h00;
        default: ins[31:26] = 6'($urandom_range(0, 63));
      endcase
      exec_instr(ins, $urandom_range(0, 3), ($urandom_range(0, 4) != 0));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    run = 1'b1;
    n = 0;
    while (state !== 3'd1 && n < 20) begin tick(); n++; end
    imem_ack = 1'b1;
    imem_data = 32'h20070003;                    // addi r7,r0,3
    tick();
    imem_ack = 1'b0;
    tick();
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL mid_exec state=%0d want=3", state);
    end
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (state !== 3'd0 || imem_req !== 1'b0 || pc !== 32'd0 || zero !== 1'b0 || retired !== 1'b0) begin
      errors++;
      $display("FAIL async_reset state=%0d req=%b pc=%h zero=%b ret=%b want 0", state, imem_req, pc, zero, retired);
    end
    check_regs("mid_reset");
    tick();
    reset = 1'b1;
    exec_instr(32'h20010005, 0, 1'b1);
    exec_instr(32'h00011022, 1, 1'b0);           // sub r2,r0,r1
  endtask

  initial begin
    model_reset();
    test_reset();
    test_program();
    test_branch();
    test_ack_delay();
    test_r0_illegal_regs();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog sim_time=%0t limit=5000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
